// File: rtl/spram_port_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// PORT_RD doubles as the reset value of the round-robin history.
package spram_port_arbiter_pkg;

    typedef enum logic {
        PORT_WR = 1'b0,
        PORT_RD = 1'b1
    } port_sel_e;

    function automatic int addrBits(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/spram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant logic: grants are combinational, the history
// register remembers which port won the last granted cycle.
module spram_port_arbiter_rr_arb2
    import spram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wr_req_i,
    input  logic rd_req_i,
    output logic wr_gnt_o,
    output logic rd_gnt_o
);

    port_sel_e lastGnt_q;
    port_sel_e lastGnt_d;

    // On a tie the port that did not win last time gets the RAM.
    always_comb begin
        wr_gnt_o  = 1'b0;
        rd_gnt_o  = 1'b0;
        lastGnt_d = lastGnt_q;
        if (!rst) begin
            if (wr_req_i && rd_req_i) begin
                wr_gnt_o = (lastGnt_q == PORT_RD);
                rd_gnt_o = (lastGnt_q == PORT_WR);
            end else begin
                wr_gnt_o = wr_req_i;
                rd_gnt_o = rd_req_i;
            end
        end
        if (wr_gnt_o) begin
            lastGnt_d = PORT_WR;
        end else if (rd_gnt_o) begin
            lastGnt_d = PORT_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGnt_q <= PORT_RD;
        end else begin
            lastGnt_q <= lastGnt_d;
        end
    end

endmodule

// File: rtl/spram_port_arbiter.sv
// Shares one single-port RAM between a write and a read requester, one access
// per cycle, and returns read data aligned to the RAM's registered read.
module spram_port_arbiter
    import spram_port_arbiter_pkg::*;
#(
    parameter  int SIZE       = 255,
    parameter  int INPUT_SIZE = 8,
    localparam int ADDR_BITS  = addrBits(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [INPUT_SIZE-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [INPUT_SIZE-1:0] rd_data,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic                  ram_w_en,
    output logic [INPUT_SIZE-1:0] ram_in,
    input  logic [INPUT_SIZE-1:0] ram_out
);

    localparam logic [ADDR_BITS:0] SizeExt = SIZE[ADDR_BITS:0];

    logic                  wrInRange;
    logic                  rdInRange;
    logic [ADDR_BITS-1:0]  holdAddr_q, holdAddr_d;
    logic [INPUT_SIZE-1:0] holdData_q, holdData_d;
    logic                  rdValid_q, rdValid_d;
    logic                  rdOob_q, rdOob_d;

    spram_port_arbiter_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .wr_req_i (wr_req),
        .rd_req_i (rd_req),
        .wr_gnt_o (wr_gnt),
        .rd_gnt_o (rd_gnt)
    );

    assign wrInRange = ({1'b0, wr_addr} < SizeExt);
    assign rdInRange = ({1'b0, rd_addr} < SizeExt);

    // Out-of-range accesses are still granted so neither requester can stall;
    // only the RAM write enable and the returned data are suppressed.
    always_comb begin
        holdAddr_d = holdAddr_q;
        holdData_d = holdData_q;
        if (wr_gnt) begin
            holdAddr_d = wr_addr;
            holdData_d = wr_data;
        end else if (rd_gnt) begin
            holdAddr_d = rd_addr;
        end
        rdValid_d = rd_gnt;
        rdOob_d   = rd_gnt & ~rdInRange;
        ram_addr  = rst ? '0 : holdAddr_d;
        ram_in    = rst ? '0 : holdData_d;
        ram_w_en  = wr_gnt & wrInRange;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            holdAddr_q <= '0;
            holdData_q <= '0;
            rdValid_q  <= 1'b0;
            rdOob_q    <= 1'b0;
        end else begin
            holdAddr_q <= holdAddr_d;
            holdData_q <= holdData_d;
            rdValid_q  <= rdValid_d;
            rdOob_q    <= rdOob_d;
        end
    end

    // A read granted just before reset must never surface during reset.
    assign rd_valid = rdValid_q & ~rst;
    assign rd_data  = (rd_valid && !rdOob_q) ? ram_out : '0;

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter: directed scenarios followed by random held
// requests, checked against a memory-array reference of the arbitration rules.
module tb_spram_port_arbiter;

    localparam int SIZE = 255;
    localparam int W    = 8;
    localparam int AB   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrReq, rdReq;
    logic [AB-1:0] wrAddr, rdAddr;
    logic [W-1:0]  wrData;
    logic          wrGnt, rdGnt, rdValid;
    logic [W-1:0]  rdData;
    logic [AB-1:0] ramAddr;
    logic          ramWEn;
    logic [W-1:0]  ramIn;
    logic [W-1:0]  ramOut;
    logic          clearMem;
    logic [W-1:0]  ramMem [0:SIZE-1];

    int            assertCount = 0;
    int            failCount   = 0;

    logic [W-1:0]  expMem [0:SIZE-1];
    bit            lastWasWrite;
    logic [AB-1:0] heldAddr;
    logic [W-1:0]  heldData;
    bit            pendValid;
    logic [W-1:0]  pendData;
    bit            mWr, mRd;

    always #5 clk = ~clk;

    spram_port_arbiter #(.SIZE(SIZE), .INPUT_SIZE(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wrReq),
        .wr_addr  (wrAddr),
        .wr_data  (wrData),
        .wr_gnt   (wrGnt),
        .rd_req   (rdReq),
        .rd_addr  (rdAddr),
        .rd_gnt   (rdGnt),
        .rd_valid (rdValid),
        .rd_data  (rdData),
        .ram_addr (ramAddr),
        .ram_w_en (ramWEn),
        .ram_in   (ramIn),
        .ram_out  (ramOut)
    );

    // Behavioural single-port RAM, registered read-before-write; reads past
    // the end return a marker so unmasked out-of-range data is visible.
    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < SIZE; i++) ramMem[i] <= '0;
            ramOut <= '0;
        end else begin
            if (ramWEn && ramAddr < SIZE) ramMem[ramAddr] <= ramIn;
            ramOut <= (ramAddr < SIZE) ? ramMem[ramAddr] : 8'hEE;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit wq, input logic [AB-1:0] wa,
                                 input logic [W-1:0] wd, input bit rq, input logic [AB-1:0] ra);
        @(posedge clk);
        #1;
        rst    = r;
        wrReq  = wq;
        wrAddr = wa;
        wrData = wd;
        rdReq  = rq;
        rdAddr = ra;
    endtask

    // Checks this cycle against the reference, then advances it past the edge.
    task automatic checkOutput();
        logic [AB-1:0] expAddr;
        bit            expValid;
        #3;
        mWr = !rst && wrReq && (!rdReq || !lastWasWrite);
        mRd = !rst && rdReq && (!wrReq || lastWasWrite);
        expAddr  = rst ? '0 : (mWr ? wrAddr : (mRd ? rdAddr : heldAddr));
        expValid = pendValid && !rst;
        checkVal("wr_gnt", 32'(wrGnt), 32'(mWr));
        checkVal("rd_gnt", 32'(rdGnt), 32'(mRd));
        checkVal("ram_addr", 32'(ramAddr), 32'(expAddr));
        checkVal("ram_w_en", 32'(ramWEn), 32'(mWr && (int'(wrAddr) < SIZE)));
        if (!mRd)
            checkVal("ram_in", 32'(ramIn), 32'(rst ? 8'h00 : (mWr ? wrData : heldData)));
        checkVal("rd_valid", 32'(rdValid), 32'(expValid));
        checkVal("rd_data", 32'(rdData), 32'(expValid ? pendData : 8'h00));
        if (rst) begin
            lastWasWrite = 1'b0;
            heldAddr     = '0;
            heldData     = '0;
            pendValid    = 1'b0;
            pendData     = '0;
        end else begin
            pendValid = mRd;
            pendData  = (mRd && int'(rdAddr) < SIZE) ? expMem[rdAddr] : 8'h00;
            if (mWr) begin
                if (int'(wrAddr) < SIZE) expMem[wrAddr] = wrData;
                lastWasWrite = 1'b1;
                heldAddr     = wrAddr;
                heldData     = wrData;
            end else if (mRd) begin
                lastWasWrite = 1'b0;
                heldAddr     = rdAddr;
            end
        end
    endtask

    initial begin
        logic [AB-1:0] wa, ra;
        bit            wHeld, rHeld;
        logic [W-1:0]  wd;

        clearMem = 1'b1;
        rst = 1'b1; wrReq = 1'b0; rdReq = 1'b0;
        wrAddr = '0; wrData = '0; rdAddr = '0;
        for (int i = 0; i < SIZE; i++) expMem[i] = '0;
        lastWasWrite = 1'b0; heldAddr = '0; heldData = '0;
        pendValid = 1'b0; pendData = '0;
        repeat (2) @(posedge clk);
        #1 clearMem = 1'b0;

        $display("[TB] reset with both requests asserted");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 8'd3, 8'h11, 1, 8'd4);
            checkOutput();
        end
        applyStimulus(0, 1, 8'd3, 8'h11, 1, 8'd4);
        checkOutput();
        checkVal("first_tie_write", 32'(wrGnt), 32'd1);
        applyStimulus(0, 0, 8'd0, 8'h00, 1, 8'd4);
        checkOutput();

        $display("[TB] write then read same address");
        applyStimulus(0, 1, 8'd5, 8'hA3, 0, 8'd0);
        checkOutput();
        applyStimulus(0, 0, 8'd0, 8'h00, 1, 8'd5);
        checkOutput();
        checkVal("wr_rd_gnt", 32'(rdGnt), 32'd1);
        applyStimulus(0, 0, 8'd0, 8'h00, 0, 8'd0);
        checkOutput();
        checkVal("wr_rd_valid", 32'(rdValid), 32'd1);
        checkVal("wr_rd_data", 32'(rdData), 32'hA3);

        $display("[TB] continuous dual requests");
        wa = 8'd0; ra = 8'd10;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, wa, 8'h40 + wa, 1, ra);
            checkOutput();
            checkVal("alternate", 32'(wrGnt), 32'(i % 2 == 0));
            if (mWr) wa++;
            if (mRd) ra++;
        end
        applyStimulus(0, 0, 8'd0, 8'h00, 0, 8'd0);
        checkOutput();

        $display("[TB] back-to-back reads");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, AB'(i), W'(8'h10 + i), 0, 8'd0);
            checkOutput();
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 8'd0, 8'h00, i < 4, AB'(i));
            checkOutput();
            if (i > 0) begin
                checkVal("stream_valid", 32'(rdValid), 32'd1);
                checkVal("stream_data", 32'(rdData), 32'(8'h10 + i - 1));
            end
        end

        $display("[TB] out-of-range address");
        applyStimulus(0, 1, 8'd254, 8'h5A, 0, 8'd0);
        checkOutput();
        applyStimulus(0, 1, 8'd255, 8'hFF, 0, 8'd0);
        checkOutput();
        checkVal("oob_wr_gnt", 32'(wrGnt), 32'd1);
        checkVal("oob_w_en", 32'(ramWEn), 32'd0);
        applyStimulus(0, 0, 8'd0, 8'h00, 1, 8'd255);
        checkOutput();
        applyStimulus(0, 0, 8'd0, 8'h00, 1, 8'd254);
        checkOutput();
        checkVal("oob_rd_valid", 32'(rdValid), 32'd1);
        checkVal("oob_rd_data", 32'(rdData), 32'h00);
        applyStimulus(0, 0, 8'd0, 8'h00, 0, 8'd0);
        checkOutput();
        checkVal("addr254_kept", 32'(rdData), 32'h5A);

        $display("[TB] reset discards in-flight read");
        applyStimulus(0, 0, 8'd0, 8'h00, 1, 8'd7);
        checkOutput();
        applyStimulus(1, 1, 8'd1, 8'h22, 1, 8'd7);
        checkOutput();
        checkVal("rst_drop_valid", 32'(rdValid), 32'd0);
        applyStimulus(0, 1, 8'd1, 8'h22, 1, 8'd7);
        checkOutput();
        checkVal("post_rst_tie", 32'(wrGnt), 32'd1);
        checkVal("post_rst_valid", 32'(rdValid), 32'd0);

        $display("[TB] random held requests");
        wHeld = 1'b0; rHeld = 1'b0; wa = '0; ra = '0; wd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!wHeld && $urandom_range(0, 3) != 0) begin
                wHeld = 1'b1;
                wa = ($urandom_range(0, 7) == 0) ? AB'($urandom_range(250, 255))
                                                 : AB'($urandom_range(0, 15));
                wd = W'($urandom);
            end
            if (!rHeld && $urandom_range(0, 3) != 0) begin
                rHeld = 1'b1;
                ra = ($urandom_range(0, 7) == 0) ? AB'($urandom_range(250, 255))
                                                 : AB'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 63) == 0, wHeld, wa, wd, rHeld, ra);
            checkOutput();
            if (mWr) wHeld = 1'b0;
            if (mRd) rHeld = 1'b0;
        end
        applyStimulus(0, 0, 8'd0, 8'h00, 0, 8'd0);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
